// File: rtl/alu_req_scheduler_if.sv
// Request, response and ALU-side signals of the two-port ALU scheduler.
// The scheduler uses the slave view; the command/response/ALU side uses the master view.
interface alu_req_scheduler_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SEL_WIDTH = 6
);
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [SEL_WIDTH-1:0] req_op0;
  logic [SEL_WIDTH-1:0] req_op1;
  logic [WIDTH-1:0]     req_a0;
  logic [WIDTH-1:0]     req_a1;
  logic [WIDTH-1:0]     req_b0;
  logic [WIDTH-1:0]     req_b1;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [OUT_WIDTH-1:0] rsp_data;
  logic                 rsp_err;

  logic [SEL_WIDTH-1:0] alu_sel;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [WIDTH-1:0]     alu_acc;
  logic [OUT_WIDTH-1:0] alu_out;

  logic                 busy;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    output rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  alu_sel, alu_a, alu_b, alu_acc, busy
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    input  rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output alu_sel, alu_a, alu_b, alu_acc, busy
  );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters, with a private
// accumulator per requester and a valid/ready response channel.
module alu_req_scheduler #(
  parameter int WIDTH       = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SEL_WIDTH   = 6,
  parameter int ALU_LATENCY = 1,
  parameter int MAX_OP      = 24
) (
  input  logic              clk,
  input  logic              reset,
  alu_req_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int              CNT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

  logic [1:0]           state_reg;
  logic                 id_reg;
  logic                 rr_reg;
  logic [SEL_WIDTH-1:0] op_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [OUT_WIDTH-1:0] rsp_data_reg;
  logic                 rsp_err_reg;

  logic [SEL_WIDTH-1:0] port_op [2];
  logic [WIDTH-1:0]     port_a  [2];
  logic [WIDTH-1:0]     port_b  [2];

  assign port_op[0] = bus.req_op0;
  assign port_op[1] = bus.req_op1;
  assign port_a[0]  = bus.req_a0;
  assign port_a[1]  = bus.req_a1;
  assign port_b[0]  = bus.req_b0;
  assign port_b[1]  = bus.req_b1;

  // Pointer port wins when it asks; otherwise the other port is offered the slot.
  logic gnt;
  logic accept;
  logic [SEL_WIDTH-1:0] gnt_op;
  logic op_zero;
  logic op_bad;
  logic in_exec;
  logic exec_last;

  assign gnt     = bus.req_valid[rr_reg] ? rr_reg : ~rr_reg;
  assign gnt_op  = port_op[gnt];
  assign op_zero = (gnt_op == '0);
  assign op_bad  = (gnt_op > SEL_WIDTH'(MAX_OP));

  always_comb begin
    bus.req_ready = 2'b00;
    if (!reset && (state_reg == IDLE) && (|bus.req_valid)) begin
      bus.req_ready = gnt ? 2'b10 : 2'b01;
    end
  end

  assign accept    = |(bus.req_valid & bus.req_ready);
  assign in_exec   = (state_reg == EXEC);
  assign exec_last = in_exec && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      id_reg       <= 1'b0;
      rr_reg       <= 1'b0;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      cnt_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            id_reg  <= gnt;
            rr_reg  <= ~gnt;
            op_reg  <= gnt_op;
            a_reg   <= port_a[gnt];
            b_reg   <= port_b[gnt];
            cnt_reg <= '0;
            // Clear and illegal opcodes never reach the ALU.
            if (op_zero || op_bad) begin
              state_reg    <= RESP;
              rsp_data_reg <= '0;
              rsp_err_reg  <= op_bad;
            end else begin
              state_reg <= EXEC;
            end
          end
        end
        EXEC: begin
          if (exec_last) begin
            state_reg    <= RESP;
            rsp_data_reg <= bus.alu_out;
            rsp_err_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One accumulator per requester; only the owner of the current op may write.
  logic                 acc_we;
  logic                 acc_wid;
  logic [WIDTH-1:0]     acc_wdata;
  logic [2*WIDTH-1:0]   acc_flat;
  logic [WIDTH-1:0]     acc_cur;

  assign acc_we    = (accept && op_zero) || exec_last;
  assign acc_wid   = (state_reg == IDLE) ? gnt : id_reg;
  assign acc_wdata = exec_last ? bus.alu_out[WIDTH-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_acc
      logic [WIDTH-1:0] acc_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (acc_we && (acc_wid == 1'(gi))) begin
          acc_reg <= acc_wdata;
        end
      end

      assign acc_flat[gi*WIDTH +: WIDTH] = acc_reg;
    end
  endgenerate

  assign acc_cur = id_reg ? acc_flat[2*WIDTH-1:WIDTH] : acc_flat[WIDTH-1:0];

  // Idle ALU sees NOT of zero; sel 0 would clear the ALU's own state.
  assign bus.alu_sel = in_exec ? op_reg  : SEL_WIDTH'(1);
  assign bus.alu_a   = in_exec ? a_reg   : '0;
  assign bus.alu_b   = in_exec ? b_reg   : '0;
  assign bus.alu_acc = in_exec ? acc_cur : '0;

  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule
